// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous sprite ROM among NPORT
// requesters. The grant is combinational in the request cycle. The owner of
// the returning ROM word is flagged one cycle later on rvalid_o.
//
// Handshake: a requester raises req_i[p] and holds req_i[p] and its address
// stable until it sees gnt_o[p] high in the same cycle. That cycle is the
// transfer. In the following cycle rvalid_o[p] is high and rdata_o carries
// the ROM word. There is no back-pressure on the read return, and nothing is
// queued. A request dropped before it is granted is simply forgotten.
module sprite_rom_arbiter #(
  parameter int NPORT  = 2,
  parameter int AW     = 10,
  parameter int DW     = 3,
  parameter int TRANSP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORT-1:0]  req_i,
  input  logic [NPORT*AW-1:0] addr_i,
  output logic [NPORT-1:0]  gnt_o,
  output logic              rom_en_o,
  output logic [AW-1:0]     rom_addr_o,
  input  logic [DW-1:0]     rom_data_i,
  output logic [DW-1:0]     rdata_o,
  output logic [NPORT-1:0]  rvalid_o,
  output logic              rtransp_o
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  // Index of the most recently granted port; the search starts one past it.
  logic [PW-1:0]    last_ptr;
  logic [NPORT-1:0] gnt;
  logic [PW-1:0]    sel;
  logic             found;
  logic [NPORT-1:0] rvalid_q;

  // Round-robin search from last_ptr+1, wrapping at NPORT. Reset masks every grant.
  always_comb begin : rr_search
    int idx;
    gnt   = '0;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NPORT; i++) begin
      idx = (int'(last_ptr) + i) % NPORT;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        sel      = PW'(idx);
      end
    end
    if (rst) begin
      gnt   = '0;
      found = 1'b0;
    end
  end

  // Route the granted port's address to the ROM. The address is 0 when idle.
  always_comb begin
    rom_addr_o = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (gnt[p]) rom_addr_o = addr_i[p*AW +: AW];
    end
  end

  assign gnt_o    = gnt;
  assign rom_en_o = found;

  // Pointer update: load the winner on a grant, hold otherwise. Reset gives port 0 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr <= PW'(NPORT - 1);
    end else if (found) begin
      last_ptr <= sel;
    end
  end

  // The grant vector delayed one cycle marks the owner of the ROM output.
  // Reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
    end
  end

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rom_data_i;
  assign rtransp_o = (|rvalid_q) && (rom_data_i == DW'(TRANSP));

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter. It uses a 2-port instance with a
// behavioural ROM, plus a 4-port instance for the fairness sequence.
module tb_sprite_rom_arbiter;

  localparam int AW = 10;
  localparam int DW = 3;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Two-port DUT.
  logic [1:0]    req;
  logic [2*AW-1:0] addr;
  logic [1:0]    gnt;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rdata;
  logic [1:0]    rvalid;
  logic          rtransp;

  sprite_rom_arbiter #(.NPORT(2), .AW(AW), .DW(DW), .TRANSP(0)) dut (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .gnt_o(gnt),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .rdata_o(rdata), .rvalid_o(rvalid), .rtransp_o(rtransp)
  );

  // Four-port DUT; only its grants are examined.
  logic [3:0]      req4;
  logic [4*AW-1:0] addr4;
  logic [3:0]      gnt4;
  logic            rom_en4;
  logic [AW-1:0]   rom_addr4;
  logic [DW-1:0]   rdata4;
  logic [3:0]      rvalid4;
  logic            rtransp4;

  sprite_rom_arbiter #(.NPORT(4), .AW(AW), .DW(DW), .TRANSP(0)) dut4 (
    .clk(clk), .rst(rst), .req_i(req4), .addr_i(addr4), .gnt_o(gnt4),
    .rom_en_o(rom_en4), .rom_addr_o(rom_addr4), .rom_data_i(3'd2),
    .rdata_o(rdata4), .rvalid_o(rvalid4), .rtransp_o(rtransp4)
  );

  // ROM contents: ROM[12]=0, ROM[13]=4, otherwise (a + a/8) mod 8.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 10'd12) return 3'd0;
    if (a == 10'd13) return 3'd4;
    return 3'(32'(a) + (32'(a) >> 3));
  endfunction

  always_ff @(posedge clk) rom_data <= rom_word(rom_addr);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [1:0]  exp_g [4];
  logic [AW-1:0] exp_a [4];
  logic [DW-1:0] exp_d [4];
  int cnt  [4];
  int last [4];
  int maxgap;

  initial begin
    req = '0; addr = '0; req4 = '0; addr4 = '0;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a = '{10'd5, 10'd900, 10'd5, 10'd900};
    exp_d = '{3'd0, 3'd5, 3'd4, 3'd5};

    // Reset state.
    tick(); tick();
    #1;
    check("rst_gnt",      32'(gnt), 0);
    check("rst_rom_en",   32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_rvalid",   32'(rvalid), 0);
    check("rst_rtransp",  32'(rtransp), 0);

    // Single requester in the first cycle after reset.
    rst = 1'b0; req = 2'b01; addr[0 +: AW] = 10'd37;
    #1;
    check("single_gnt",  32'(gnt), 1);
    check("single_en",   32'(rom_en), 1);
    check("single_addr", 32'(rom_addr), 37);
    tick();
    req = 2'b00;
    #1;
    check("single_rvalid", 32'(rvalid), 1);
    check("single_rdata",  32'(rdata), 1);
    check("single_idle_gnt",  32'(gnt), 0);
    check("single_idle_addr", 32'(rom_addr), 0);

    // Contention from a fresh reset: alternating grants.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11; addr[0 +: AW] = 10'd5; addr[AW +: AW] = 10'd900;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_gnt",  32'(gnt), 32'(exp_g[k]));
      check("cont_addr", 32'(rom_addr), 32'(exp_a[k]));
      if (k > 0) begin
        check("cont_rvalid", 32'(rvalid), 32'(exp_g[k-1]));
        check("cont_rdata",  32'(rdata), 32'(exp_d[k]));
      end
      tick();
    end
    req = 2'b00;
    #1;
    check("cont_last_rvalid", 32'(rvalid), 2);
    check("cont_last_rdata",  32'(rdata), 4);
    tick();

    // Idle gap: port 1 wins, three idle cycles, then port 0 wins the tie.
    req = 2'b10;
    #1;
    check("gap_gnt1", 32'(gnt), 2);
    tick();
    req = 2'b00;
    #1;
    check("gap_rvalid1", 32'(rvalid), 2);
    check("gap_idle_en", 32'(rom_en), 0);
    tick(); tick();
    #1;
    check("gap_idle_rvalid", 32'(rvalid), 0);
    tick();
    req = 2'b11;
    #1;
    check("gap_tie_gnt", 32'(gnt), 1);
    tick();
    req = 2'b00;

    // Transparency on port 1.
    req = 2'b10; addr[AW +: AW] = 10'd12;
    #1;
    check("tr_gnt",  32'(gnt), 2);
    check("tr_addr", 32'(rom_addr), 12);
    tick();
    addr[AW +: AW] = 10'd13;
    #1;
    check("tr_rvalid12",  32'(rvalid), 2);
    check("tr_rdata12",   32'(rdata), 0);
    check("tr_rtransp12", 32'(rtransp), 1);
    tick();
    req = 2'b00;
    #1;
    check("tr_rvalid13",  32'(rvalid), 2);
    check("tr_rdata13",   32'(rdata), 4);
    check("tr_rtransp13", 32'(rtransp), 0);
    tick();
    #1;
    check("tr_rtransp_idle", 32'(rtransp), 0);

    // Reset with a read in flight. Port 0 wins first, so without reset port 1 would be next.
    req = 2'b01; addr[0 +: AW] = 10'd5;
    #1;
    check("rr_pre_gnt", 32'(gnt), 1);
    tick();
    rst = 1'b1;
    #1;
    check("rr_rst_gnt",  32'(gnt), 0);
    check("rr_rst_en",   32'(rom_en), 0);
    check("rr_rst_addr", 32'(rom_addr), 0);
    tick();
    #1;
    check("rr_dropped_rvalid", 32'(rvalid), 0);
    check("rr_dropped_transp", 32'(rtransp), 0);
    rst = 1'b0; req = 2'b11;
    #1;
    check("rr_after_gnt", 32'(gnt), 1);
    tick();
    req = 2'b00;
    #1;
    check("rr_after_rvalid", 32'(rvalid), 1);
    check("rr_after_rdata",  32'(rdata), 5);
    tick();

    // Fairness on four ports: 16 cycles with every port requesting.
    for (int p = 0; p < 4; p++) begin cnt[p] = 0; last[p] = -1; end
    maxgap = 0;
    req4 = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("rr4_gnt", 32'(gnt4), 32'(1) << (k % 4));
      for (int p = 0; p < 4; p++) begin
        if (gnt4[p]) begin
          cnt[p]++;
          if (k - last[p] > maxgap) maxgap = k - last[p];
          last[p] = k;
        end
      end
      tick();
    end
    for (int p = 0; p < 4; p++) check("rr4_count", 32'(cnt[p]), 4);
    check("rr4_maxwait_ok", 32'(maxgap <= 4), 1);

    // A request dropped in the cycle it would have won is not granted.
    req4 = 4'b0000;
    #1;
    check("rr4_drop_gnt", 32'(gnt4), 0);
    check("rr4_drop_en",  32'(rom_en4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
